uart_rx_word_packer: RTL and testbench

Upstream feeder for the beamformer dual-port sample RAM. It consumes bytes from the UART receiver (RX_DATA/RX_BUSY) and packs each group of 4 bytes little-endian into a 32-bit word. It writes each word to the RAM write port at consecutive addresses and flags completion after FRAME_WORDS words. The block also provides an arm/abort control and an inter-byte timeout that discards partial words.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_word_packer_rx_busy_edge.sv | 22 ++
 rtl/uart_rx_word_packer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_word_packer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: packer state encoding, word geometry
// and the default frame length also used by the TX/readback side.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } rxState_t;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEFAULT_FRAME_WORDS = 768;

  // Little-endian placement: lane 0 is bits [7:0], lane 3 is bits [31:24].
  function automatic logic [31:0] insertLane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_word_packer_rx_busy_edge.sv
// Turns the UART receiver busy flag into a single-cycle strobe on its falling edge,
// which is the moment the received byte is valid.
module rx_busy_edge (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic rxBusy_i,
  output logic byteStb_o
);

  logic busy_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= rxBusy_i;
    end
  end

  assign byteStb_o = busy_q & ~rxBusy_i;

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes little-endian into 32-bit words and writes them to
// consecutive sample-RAM addresses, one frame of FRAME_WORDS words per arm.
module uart_rx_word_packer
  import uart_rx_pkg::*;
#(
  parameter int FRAME_WORDS    = DEFAULT_FRAME_WORDS,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              ARM,
  input  logic              ABORT,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_BUSY,
  output logic [31:0]       WR_DATA,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              WR_EN,
  output logic              FRAME_DONE,
  output logic              ACTIVE,
  output logic              TIMEOUT_ERR
);

  localparam int                CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [1:0]        LAST_IDX      = 2'(BYTES_PER_WORD - 1);

  rxState_t          state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       wrData_q, wrData_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic              byteStb;
  logic              lastAddr;

  rx_busy_edge uBusyEdge (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .rxBusy_i  (RX_BUSY),
    .byteStb_o (byteStb)
  );

  assign lastAddr = (wrAddr_q == LAST_ADDR);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ARM) state_d = COLLECT;
        COLLECT: if (byteStb && (idx_q == LAST_IDX)) state_d = WRITE;
        WRITE:   state_d = lastAddr ? DONE : COLLECT;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    WR_EN       = (state_q == WRITE);
    FRAME_DONE  = (state_q == DONE);
    ACTIVE      = (state_q == COLLECT) || (state_q == WRITE);
    WR_DATA     = wrData_q;
    WR_ADDR     = wrAddr_q;
    TIMEOUT_ERR = timeoutErr_q;
  end

  // The gap counter only runs while a word is partially assembled; a byte strobe
  // is evaluated before the limit so a byte landing on the limit cycle is kept.
  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    wrData_d     = wrData_q;
    wrAddr_d     = wrAddr_q;
    cnt_d        = '0;
    timeoutErr_d = timeoutErr_q;
    if (ABORT) begin
      idx_d    = '0;
      wrAddr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ARM) begin
            idx_d        = '0;
            wrAddr_d     = '0;
            timeoutErr_d = 1'b0;
          end
        end
        COLLECT: begin
          if (byteStb) begin
            if (idx_q == LAST_IDX) begin
              wrData_d = insertLane(asm_q, idx_q, RX_DATA);
              idx_d    = '0;
            end else begin
              asm_d = insertLane(asm_q, idx_q, RX_DATA);
              idx_d = idx_q + 2'd1;
            end
          end else if (idx_q != '0) begin
            if (cnt_q == TIMEOUT_LIMIT) begin
              idx_d        = '0;
              timeoutErr_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (!lastAddr) begin
            wrAddr_d = wrAddr_q + ADDR_W'(1);
          end
          if (byteStb) begin
            asm_d = insertLane(asm_q, 2'd0, RX_DATA);
            idx_d = 2'd1;
          end
        end
        DONE: begin
          wrAddr_d = '0;
        end
        default: begin
          idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q        <= '0;
      asm_q        <= '0;
      wrData_q     <= '0;
      wrAddr_q     <= '0;
      cnt_q        <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      wrData_q     <= wrData_d;
      wrAddr_q     <= wrAddr_d;
      cnt_q        <= cnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer: a transaction-level model predicts the
// outputs every cycle, directed scenarios pin literal values, then random traffic runs.
module tb_uart_rx_word_packer;

  localparam int FW     = 4;
  localparam int TO     = 50;
  localparam int ADDR_W = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_CAP  = 1;
  localparam int PH_WR   = 2;
  localparam int PH_DONE = 3;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N  = 1'b1;
  logic              ARM      = 1'b0;
  logic              ABORT    = 1'b0;
  logic [7:0]        RX_DATA  = 8'h00;
  logic              RX_BUSY  = 1'b0;
  logic [31:0]       WR_DATA;
  logic [ADDR_W-1:0] WR_ADDR;
  logic              WR_EN;
  logic              FRAME_DONE;
  logic              ACTIVE;
  logic              TIMEOUT_ERR;

  int nCompared   = 0;
  int nMismatched = 0;
  bit chkOn       = 1'b0;

  // Model state: what the frame capture must look like from the outside.
  int          mPhase    = PH_IDLE;
  logic [7:0]  mBytes[$];
  logic        mPrevBusy = 1'b0;
  logic        mStb      = 1'b0;
  logic        mWrEn     = 1'b0;
  logic        mDone     = 1'b0;
  logic        mErr      = 1'b0;
  logic [31:0] mWrData   = '0;
  int          mWrAddr   = 0;
  int          cycleNo   = 0;
  int          mLastByte = 0;

  logic [31:0] logData[$];
  int          logAddr[$];
  int          doneCnt = 0;

  uart_rx_word_packer #(
    .FRAME_WORDS    (FW),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .ARM         (ARM),
    .ABORT       (ABORT),
    .RX_DATA     (RX_DATA),
    .RX_BUSY     (RX_BUSY),
    .WR_DATA     (WR_DATA),
    .WR_ADDR     (WR_ADDR),
    .WR_EN       (WR_EN),
    .FRAME_DONE  (FRAME_DONE),
    .ACTIVE      (ACTIVE),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] packWord(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one step per clock edge, using the inputs as they stood before the edge.
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mPhase    = PH_IDLE;
      mBytes.delete();
      mPrevBusy = 1'b0;
      mWrEn     = 1'b0;
      mDone     = 1'b0;
      mErr      = 1'b0;
      mWrData   = '0;
      mWrAddr   = 0;
    end else begin
      cycleNo++;
      mStb      = mPrevBusy && !RX_BUSY;
      mPrevBusy = RX_BUSY;
      mWrEn     = 1'b0;
      mDone     = 1'b0;
      if (ABORT) begin
        mPhase  = PH_IDLE;
        mBytes.delete();
        mWrAddr = 0;
      end else begin
        case (mPhase)
          PH_IDLE: begin
            if (ARM) begin
              mPhase  = PH_CAP;
              mBytes.delete();
              mErr    = 1'b0;
              mWrAddr = 0;
            end
          end
          PH_CAP: begin
            if (mStb) begin
              mBytes.push_back(RX_DATA);
              mLastByte = cycleNo;
              if (mBytes.size() == 4) begin
                mWrData = packWord(mBytes[0], mBytes[1], mBytes[2], mBytes[3]);
                mBytes.delete();
                mWrEn  = 1'b1;
                mPhase = PH_WR;
              end
            end else if (mBytes.size() != 0 && (cycleNo - mLastByte) == TO + 1) begin
              mBytes.delete();
              mErr = 1'b1;
            end
          end
          PH_WR: begin
            if (mWrAddr == FW - 1) begin
              mDone  = 1'b1;
              mPhase = PH_DONE;
            end else begin
              mWrAddr++;
              mPhase = PH_CAP;
            end
            if (mStb) begin
              mBytes.delete();
              mBytes.push_back(RX_DATA);
              mLastByte = cycleNo;
            end
          end
          default: begin
            mWrAddr = 0;
            mPhase  = PH_IDLE;
          end
        endcase
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (chkOn) begin
      checkOutput("wr_en", 32'(WR_EN), 32'(mWrEn));
      checkOutput("wr_data", WR_DATA, mWrData);
      checkOutput("wr_addr", 32'(WR_ADDR), 32'(mWrAddr));
      checkOutput("frame_done", 32'(FRAME_DONE), 32'(mDone));
      checkOutput("active", 32'(ACTIVE), 32'((mPhase == PH_CAP) || (mPhase == PH_WR)));
      checkOutput("timeout_err", 32'(TIMEOUT_ERR), 32'(mErr));
      if (WR_EN) begin
        logData.push_back(WR_DATA);
        logAddr.push_back(int'(WR_ADDR));
      end
      if (FRAME_DONE) doneCnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One UART byte: busy for busyLen cycles, then the byte appears as busy falls.
  task automatic applyStimulus(input logic [7:0] b, input int busyLen);
    @(negedge CLOCK_50);
    RX_BUSY = 1'b1;
    RX_DATA = 8'($urandom);
    repeat (busyLen) @(negedge CLOCK_50);
    RX_DATA = b;
    RX_BUSY = 1'b0;
  endtask

  task automatic pulseArm();
    @(negedge CLOCK_50);
    ARM = 1'b1;
    @(negedge CLOCK_50);
    ARM = 1'b0;
  endtask

  task automatic pulseAbort();
    @(negedge CLOCK_50);
    ABORT = 1'b1;
    @(negedge CLOCK_50);
    ABORT = 1'b0;
  endtask

  initial begin
    int base;
    int r;

    #2 RESET_N = 1'b0;
    #3;
    checkOutput("rst_wr_data", WR_DATA, 32'h0);
    checkOutput("rst_wr_addr", 32'(WR_ADDR), 32'h0);
    checkOutput("rst_wr_en", 32'(WR_EN), 32'h0);
    checkOutput("rst_frame_done", 32'(FRAME_DONE), 32'h0);
    checkOutput("rst_active", 32'(ACTIVE), 32'h0);
    checkOutput("rst_timeout_err", 32'(TIMEOUT_ERR), 32'h0);
    tick(2);
    RESET_N = 1'b1;
    chkOn   = 1'b1;

    // Single word, write one cycle after the fourth strobe.
    pulseArm();
    applyStimulus(8'h11, 2);
    applyStimulus(8'h22, 3);
    applyStimulus(8'h33, 1);
    applyStimulus(8'h44, 2);
    @(posedge CLOCK_50);
    #1;
    checkOutput("t1_wr_en", 32'(WR_EN), 32'h1);
    checkOutput("t1_wr_data", WR_DATA, 32'h44332211);
    checkOutput("t1_wr_addr", 32'(WR_ADDR), 32'h0);
    checkOutput("t1_model_data", mWrData, 32'h44332211);

    // Full frame of four words, then FRAME_DONE and back to IDLE.
    pulseAbort();
    pulseArm();
    base = logData.size();
    r    = doneCnt;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1 + (i % 3));
    tick(4);
    checkOutput("t2_nwrites", 32'(logData.size() - base), 32'd4);
    if (logData.size() - base == 4) begin
      checkOutput("t2_w0", logData[base], 32'h03020100);
      checkOutput("t2_w1", logData[base + 1], 32'h07060504);
      checkOutput("t2_w2", logData[base + 2], 32'h0B0A0908);
      checkOutput("t2_w3", logData[base + 3], 32'h0F0E0D0C);
      checkOutput("t2_a3", 32'(logAddr[base + 3]), 32'd3);
    end
    checkOutput("t2_done_pulses", 32'(doneCnt - r), 32'd1);
    checkOutput("t2_addr_idle", 32'(WR_ADDR), 32'h0);
    checkOutput("t2_active_idle", 32'(ACTIVE), 32'h0);

    // Timeout discards a partial word; next word lands at address 0.
    pulseArm();
    base = logData.size();
    applyStimulus(8'hAA, 2);
    applyStimulus(8'hBB, 2);
    tick(60);
    checkOutput("t3_no_write", 32'(logData.size() - base), 32'd0);
    checkOutput("t3_timeout_err", 32'(TIMEOUT_ERR), 32'h1);
    checkOutput("t3_model_err", 32'(mErr), 32'h1);
    applyStimulus(8'h01, 2);
    applyStimulus(8'h02, 2);
    applyStimulus(8'h03, 2);
    applyStimulus(8'h04, 2);
    @(posedge CLOCK_50);
    #1;
    checkOutput("t3_wr_data", WR_DATA, 32'h04030201);
    checkOutput("t3_wr_addr", 32'(WR_ADDR), 32'h0);

    // Abort in the middle of the third word.
    pulseAbort();
    pulseArm();
    base = logData.size();
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h20 + i), 2);
    applyStimulus(8'h30, 2);
    applyStimulus(8'h31, 2);
    tick(2);
    checkOutput("t4_nwrites", 32'(logData.size() - base), 32'd2);
    if (logData.size() - base == 2) checkOutput("t4_a1", 32'(logAddr[base + 1]), 32'd1);
    pulseAbort();
    tick(2);
    checkOutput("t4_addr_abort", 32'(WR_ADDR), 32'h0);
    checkOutput("t4_active_abort", 32'(ACTIVE), 32'h0);
    checkOutput("t4_no_extra", 32'(logData.size() - base), 32'd2);
    pulseArm();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hC0 + i), 1);
    @(posedge CLOCK_50);
    #1;
    checkOutput("t4_rearm_data", WR_DATA, 32'hC3C2C1C0);
    checkOutput("t4_rearm_addr", 32'(WR_ADDR), 32'h0);

    // Bytes in IDLE are ignored.
    pulseAbort();
    base = logData.size();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h70 + i), 2);
    tick(3);
    checkOutput("t5_idle_no_write", 32'(logData.size() - base), 32'd0);
    checkOutput("t5_idle_active", 32'(ACTIVE), 32'h0);

    // Strobe on the exact timeout cycle wins; one cycle later it does not.
    pulseArm();
    applyStimulus(8'h5A, 2);
    tick(40);
    RX_BUSY = 1'b1;
    tick(11);
    RX_DATA = 8'h5B;
    RX_BUSY = 1'b0;
    tick(3);
    checkOutput("t5_coincident_err", 32'(TIMEOUT_ERR), 32'h0);
    checkOutput("t5_model_err0", 32'(mErr), 32'h0);
    tick(38);
    RX_BUSY = 1'b1;
    tick(11);
    RX_DATA = 8'h5C;
    RX_BUSY = 1'b0;
    tick(2);
    checkOutput("t5_late_err", 32'(TIMEOUT_ERR), 32'h1);
    base = logData.size();
    applyStimulus(8'h5D, 1);
    applyStimulus(8'h5E, 1);
    applyStimulus(8'h5F, 1);
    tick(3);
    checkOutput("t5_late_nwrites", 32'(logData.size() - base), 32'd1);
    if (logData.size() - base == 1) begin
      checkOutput("t5_late_word", logData[base], 32'h5F5E5D5C);
      checkOutput("t5_late_addr", 32'(logAddr[base]), 32'd0);
    end

    // Asynchronous reset between clock edges, mid-word.
    pulseAbort();
    pulseArm();
    applyStimulus(8'hE0, 2);
    applyStimulus(8'hE1, 2);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b0;
    #1;
    checkOutput("t6_rst_active", 32'(ACTIVE), 32'h0);
    checkOutput("t6_rst_addr", 32'(WR_ADDR), 32'h0);
    checkOutput("t6_rst_data", WR_DATA, 32'h0);
    checkOutput("t6_rst_err", 32'(TIMEOUT_ERR), 32'h0);
    tick(2);
    RESET_N = 1'b1;
    pulseArm();
    base = logData.size();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i), 2);
    tick(3);
    checkOutput("t6_nwrites", 32'(logData.size() - base), 32'd1);
    if (logData.size() - base == 1) begin
      checkOutput("t6_word", logData[base], 32'h13121110);
      checkOutput("t6_addr", 32'(logAddr[base]), 32'd0);
    end

    // Random traffic: bytes, idle gaps around the timeout, arm and abort pulses.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) pulseAbort();
      else if (r < 12) pulseArm();
      else if (r < 18) tick(int'($urandom_range(1, 70)));
      else applyStimulus(8'($urandom), int'($urandom_range(1, 4)));
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
